// File: rtl/clkdiv_update_sched.sv
// Round-robin scheduler for divide-ratio updates into one clock divider.
// Issues one update at a time and waits a fixed settle time after each ack.
module clkdiv_update_sched #(
  parameter int NUM_REQ       = 3,
  parameter int DIV_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int RESET_DIV     = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*DIV_WIDTH-1:0] req_div_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic [DIV_WIDTH-1:0]         clk_div_o,
  output logic                         clk_div_valid_o,
  input  logic                         clk_div_ack_i,
  output logic [DIV_WIDTH-1:0]         cur_div_o,
  output logic                         busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic [IW-1:0]        win_q, win_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cur_q, cur_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [IW-1:0]        win;
  logic [DIV_WIDTH-1:0] win_div;
  logic [NUM_REQ-1:0]   win_oh;
  int                   idx;

  // Descending scan so the requester closest to the pointer wins.
  always_comb begin
    win = ptr_q;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[idx]) win = IW'(idx);
    end
  end

  always_comb begin
    win_div = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == win) win_div = req_div_i[i*DIV_WIDTH +: DIV_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = 1'b0;
    win_d   = win_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    div_d   = div_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_q) begin
          if (pend_q == cur_q) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            div_d   = pend_q;
          end
        end else if (|req_i) begin
          gnt_d  = 1'b1;
          win_d  = win;
          pend_d = win_div;
          ptr_d  = (win == LAST) ? '0 : win + 1'b1;
        end
      end
      ISSUE: begin
        if (clk_div_ack_i) begin
          cur_d = div_q;
          if (SETTLE_CYCLES == 0) begin
            state_d = DONE;
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = DONE;
        else cnt_d = cnt_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      win_q   <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
      div_q   <= RST_DIV;
      cur_q   <= RST_DIV;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  assign win_oh          = NUM_REQ'(1) << win_q;
  assign gnt_o           = gnt_q ? win_oh : '0;
  assign done_o          = (state_q == DONE) ? win_oh : '0;
  assign clk_div_o       = div_q;
  assign clk_div_valid_o = (state_q == ISSUE);
  assign cur_div_o       = cur_q;
  assign busy_o          = (state_q != IDLE) || gnt_q;

endmodule
